// File: rtl/marcador_puntos.sv
// -----------------------------------------------------------------------------
// marcador_puntos
//   Score keeper for the LED game. It counts the ModifA/ModifB point pulses
//   coming from the Control FSM. Modo selects what each pulse does: 1 awards a
//   point and 0 takes one away, stopping at zero. The first player to reach
//   META wins. The result is held until the next rising edge of Start.
//
//   Optional feature macro: MARCADOR_DISPLAY_EN
//     When this macro is defined, the block adds a two-digit multiplexed
//     7-segment driver (Segmentos/Anodos). When it is not defined, those ports
//     and their logic are absent.
//
// Ports
//   clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Start      in   player start level; only its rising edge is used
//   ModifA/B   in   1-cycle point pulses from Control
//   Modo       in   1 = +1, 0 = -1 (saturating at 0), sampled with ModifA/B
//   PuntosA/B  out  player scores
//   GanadorA/B out  winner flags (both high on a tie)
//   Fin        out  game over
//   Segmentos  out  active-low segments, bit0=a .. bit6=g  (display build only)
//   Anodos     out  active-low digit enables, [0]=A [1]=B (display build only)
//
// States
//   INACTIVO | after reset, waiting for the first Start edge; pulses ignored
//   JUEGO    | game running, pulses update the scores
//   FIN      | a player reached META; result held, pulses ignored
// -----------------------------------------------------------------------------
module marcador_puntos #(
  parameter int PUNTOS_W = 4,
  parameter int META     = 9
`ifdef MARCADOR_DISPLAY_EN
  ,
  parameter int DIV      = 50000
`endif
) (
  input  logic                clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                ModifA,
  input  logic                ModifB,
  input  logic                Modo,
  output logic [PUNTOS_W-1:0] PuntosA,
  output logic [PUNTOS_W-1:0] PuntosB,
  output logic                GanadorA,
  output logic                GanadorB,
  output logic                Fin
`ifdef MARCADOR_DISPLAY_EN
  ,
  output logic [6:0]          Segmentos,
  output logic [1:0]          Anodos
`endif
);

  typedef enum logic [1:0] {INACTIVO, JUEGO, FIN} estado_t;

  localparam logic [PUNTOS_W-1:0] META_V = PUNTOS_W'(META);

  estado_t             estado_q;
  logic                start_q;
  logic [PUNTOS_W-1:0] puntos_a_q, puntos_b_q;
  logic [PUNTOS_W-1:0] puntos_a_d, puntos_b_d;
  logic                gan_a_q, gan_b_q, fin_q;
  logic                inicio;

  // Increments stop at META, so the score register can never overflow.
  function automatic logic [PUNTOS_W-1:0] sig_puntos(
    input logic [PUNTOS_W-1:0] p,
    input logic                modif,
    input logic                modo
  );
    logic [PUNTOS_W-1:0] r;
    r = p;
    if (modif) begin
      if (modo) begin
        if (p < META_V) r = p + PUNTOS_W'(1);
      end else if (p != '0) begin
        r = p - PUNTOS_W'(1);
      end
    end
    return r;
  endfunction

  always_comb begin
    inicio     = Start & ~start_q;
    puntos_a_d = sig_puntos(puntos_a_q, ModifA, Modo);
    puntos_b_d = sig_puntos(puntos_b_q, ModifB, Modo);
  end

  // A start edge has priority over a pulse in the same cycle, so the pulse is
  // dropped and the new game begins at 0-0.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      estado_q   <= INACTIVO;
      start_q    <= 1'b0;
      puntos_a_q <= '0;
      puntos_b_q <= '0;
      gan_a_q    <= 1'b0;
      gan_b_q    <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      start_q <= Start;
      if (inicio) begin
        estado_q   <= JUEGO;
        puntos_a_q <= '0;
        puntos_b_q <= '0;
        gan_a_q    <= 1'b0;
        gan_b_q    <= 1'b0;
        fin_q      <= 1'b0;
      end else begin
        case (estado_q)
          JUEGO: begin
            puntos_a_q <= puntos_a_d;
            puntos_b_q <= puntos_b_d;
            if (puntos_a_d == META_V || puntos_b_d == META_V) begin
              gan_a_q  <= (puntos_a_d == META_V);
              gan_b_q  <= (puntos_b_d == META_V);
              fin_q    <= 1'b1;
              estado_q <= FIN;
            end
          end
          INACTIVO, FIN: ;
          default: estado_q <= INACTIVO;
        endcase
      end
    end
  end

  assign PuntosA  = puntos_a_q;
  assign PuntosB  = puntos_b_q;
  assign GanadorA = gan_a_q;
  assign GanadorB = gan_b_q;
  assign Fin      = fin_q;

`ifdef MARCADOR_DISPLAY_EN
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]    div_q;
  logic                sel_q;
  logic [6:0]          seg_q;
  logic [1:0]          an_q;
  logic [PUNTOS_W+3:0] ext;
  logic [3:0]          digito;
  logic                blanco;
  logic [6:0]          hex_seg;

  always_comb begin
    // Zero-extend first so that narrow score widths still yield a 4-bit digit.
    ext     = {4'b0000, (sel_q ? puntos_b_q : puntos_a_q)};
    digito  = ext[3:0];
    // Blank the loser's digit once the game is over. On a tie both flags are set.
    blanco  = fin_q & (sel_q ? ~gan_b_q : ~gan_a_q);
    hex_seg = 7'h7F;
    case (digito)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      div_q <= '0;
      sel_q <= 1'b0;
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
    end else begin
      if (div_q == CNT_W'(DIV - 1)) begin
        div_q <= '0;
        sel_q <= ~sel_q;
      end else begin
        div_q <= div_q + CNT_W'(1);
      end
      seg_q <= blanco ? 7'h7F : hex_seg;
      an_q  <= sel_q ? 2'b01 : 2'b10;
    end
  end

  assign Segmentos = seg_q;
  assign Anodos    = an_q;
`endif

endmodule

// File: tb/tb_marcador_puntos.sv
module tb_marcador_puntos;

  logic       clock = 1'b0;
  logic       Reset;
  logic       Start, ModifA, ModifB, Modo;
  logic [3:0] PuntosA, PuntosB;
  logic       GanadorA, GanadorB, Fin;
`ifdef MARCADOR_DISPLAY_EN
  logic [6:0] Segmentos;
  logic [1:0] Anodos;
`endif

  int n_chk = 0;
  int n_err = 0;

  marcador_puntos dut (
    .clock    (clock),
    .Reset    (Reset),
    .Start    (Start),
    .ModifA   (ModifA),
    .ModifB   (ModifB),
    .Modo     (Modo),
    .PuntosA  (PuntosA),
    .PuntosB  (PuntosB),
    .GanadorA (GanadorA),
    .GanadorB (GanadorB),
    .Fin      (Fin)
`ifdef MARCADOR_DISPLAY_EN
    ,
    .Segmentos(Segmentos),
    .Anodos   (Anodos)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulso(input logic a, input logic b, input logic m);
    ModifA = a; ModifB = b; Modo = m;
    tick();
    ModifA = 1'b0; ModifB = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int pa, input int pb,
                         input int ga, input int gb, input int f);
    chk({tag, ".PuntosA"},  PuntosA,  pa);
    chk({tag, ".PuntosB"},  PuntosB,  pb);
    chk({tag, ".GanadorA"}, GanadorA, ga);
    chk({tag, ".GanadorB"}, GanadorB, gb);
    chk({tag, ".Fin"},      Fin,      f);
  endtask

  task automatic nuevo_juego();
    Start = 1'b0;
    tick();
    Start = 1'b1;
    tick();
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b1; ModifA = 1'b0; ModifB = 1'b0; Modo = 1'b1;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
`ifdef MARCADOR_DISPLAY_EN
    chk("reset.Anodos", Anodos, 3);
    chk("reset.Segmentos", Segmentos, 127);
`endif
    @(negedge clock); @(negedge clock);
    Reset = 1'b1;
    tick();
    chk_all("t1.juego", 0, 0, 0, 0, 0);

    // t2: nine awards to A win the game; a tenth pulse has no effect.
    for (int i = 1; i <= 9; i++) begin
      pulso(1'b1, 1'b0, 1'b1);
      chk($sformatf("t2.a%0d", i), PuntosA, i);
      chk($sformatf("t2.fin%0d", i), Fin, (i == 9) ? 1 : 0);
    end
    chk_all("t2.win", 9, 0, 1, 0, 1);
    pulso(1'b1, 1'b0, 1'b1);
    chk_all("t2.extra", 9, 0, 1, 0, 1);
    pulso(1'b1, 1'b0, 1'b0);
    chk_all("t2.fin_ignora", 9, 0, 1, 0, 1);

    // t3: a penalty at zero saturates, and from 2 two penalties give 0.
    nuevo_juego();
    chk_all("t3.nuevo", 0, 0, 0, 0, 0);
    pulso(1'b0, 1'b1, 1'b0);
    chk("t3.b_sat", PuntosB, 0);
    pulso(1'b0, 1'b1, 1'b1);
    pulso(1'b0, 1'b1, 1'b1);
    chk("t3.b2", PuntosB, 2);
    pulso(1'b0, 1'b1, 1'b0);
    chk("t3.b1", PuntosB, 1);
    pulso(1'b0, 1'b1, 1'b0);
    chk("t3.b0", PuntosB, 0);

    // Restart while still in JUEGO: score A=3, then inicio together with a pulse.
    for (int i = 0; i < 3; i++) pulso(1'b1, 1'b0, 1'b1);
    chk("t3.a3", PuntosA, 3);
    Start = 1'b0;
    tick();
    Start = 1'b1; ModifA = 1'b1; Modo = 1'b1;
    tick();
    ModifA = 1'b0;
    chk_all("t3.reinicio", 0, 0, 0, 0, 0);

    // t4: tie at META.
    for (int i = 0; i < 8; i++) pulso(1'b1, 1'b1, 1'b1);
    chk_all("t4.ocho", 8, 8, 0, 0, 0);
    pulso(1'b1, 1'b1, 1'b1);
    chk_all("t4.empate", 9, 9, 1, 1, 1);

    // t5: in FIN, a Start edge combined with a pulse starts a new game at 0-0.
    Start = 1'b0;
    tick();
    Start = 1'b1; ModifA = 1'b1; Modo = 1'b1;
    tick();
    ModifA = 1'b0;
    chk_all("t5.inicio", 0, 0, 0, 0, 0);
    pulso(1'b1, 1'b0, 1'b1);
    chk("t5.juego", PuntosA, 1);

    // t6: an asynchronous reset in the middle of a game.
    for (int i = 0; i < 4; i++) pulso(1'b1, 1'b0, 1'b1);
    chk("t6.a5", PuntosA, 5);
    #2;
    Reset = 1'b0;
    #1;
    chk_all("t6.async", 0, 0, 0, 0, 0);
    Start = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    tick();
    pulso(1'b1, 1'b0, 1'b1);
    chk("t6.inactivo_ignora", PuntosA, 0);
    Start = 1'b1;
    tick();
    pulso(1'b1, 1'b0, 1'b1);
    chk("t6.juego", PuntosA, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
